// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, arbiter FSM states and opcode legality helper.
package alu_pkg;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_AND;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio_q;  // 1: req[1] wins a tie

  always_comb begin
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else if (accept && (gnt != 2'b00)) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two valid/ready requesters, returning
// result, carry-out and an illegal-opcode flag to the granted requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp0_cout,
  output logic             rsp1_cout,
  output logic             rsp0_err,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_c_in,
  output logic             alu_enbl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             busy
);

  localparam logic [3:0] LatCnt = 4'(ALU_LAT);

  state_e           state;
  logic [3:0]       cnt;
  logic             gid;
  logic [1:0]       rsp_vld;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_c;
  logic             rsp_e;

  logic             idle;
  logic [1:0]       req_vec;
  logic [1:0]       gnt;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;

  // Reset gating keeps ready low while rst is asserted, even with requests pending.
  assign idle    = (state == ST_IDLE) && rst;
  assign req_vec = {req1_valid, req0_valid} & {2{idle}};
  assign accept  = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .gnt    (gnt)
  );

  assign sel_a  = gnt[1] ? req1_a  : req0_a;
  assign sel_b  = gnt[1] ? req1_b  : req0_b;
  assign sel_op = gnt[1] ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gid      <= 1'b0;
      rsp_vld  <= 2'b00;
      rsp_res  <= '0;
      rsp_c    <= 1'b0;
      rsp_e    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      alu_c_in <= 1'b0;
      alu_enbl <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            gid <= gnt[1];
            if (op_is_legal(sel_op)) begin
              alu_a    <= sel_a;
              alu_b    <= sel_b;
              alu_op   <= sel_op;
              alu_c_in <= (sel_op == OP_SUB);
              alu_enbl <= 1'b1;
              cnt      <= LatCnt;
              state    <= ST_EXEC;
            end else begin
              // Illegal opcodes never reach the ALU.
              rsp_res <= '0;
              rsp_c   <= 1'b0;
              rsp_e   <= 1'b1;
              rsp_vld <= gnt;
              state   <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd1) begin
            rsp_res  <= alu_result;
            rsp_c    <= alu_cout;
            rsp_e    <= 1'b0;
            alu_enbl <= 1'b0;
            rsp_vld  <= {gid, ~gid};
            cnt      <= '0;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if ((rsp_vld & {rsp1_ready, rsp0_ready}) != 2'b00) begin
            rsp_vld <= 2'b00;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign rsp0_valid  = rsp_vld[0];
  assign rsp1_valid  = rsp_vld[1];
  assign rsp0_result = rsp_res;
  assign rsp1_result = rsp_res;
  assign rsp0_cout   = rsp_c;
  assign rsp1_cout   = rsp_c;
  assign rsp0_err    = rsp_e;
  assign rsp1_err    = rsp_e;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_cout, rsp1_cout, rsp0_err, rsp1_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_c_in, alu_enbl, alu_cout, busy;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_cout(rsp0_cout), .rsp1_cout(rsp1_cout),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
    .alu_enbl(alu_enbl), .alu_result(alu_result), .alu_cout(alu_cout),
    .busy(busy)
  );

  // ALU stand-in: result settles within one cycle of the operands being applied.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic cin);
    case (op)
      OP_MOV:  return {1'b0, a};
      OP_NOT:  return {1'b0, ~a};
      OP_ADD:  return {1'b0, a} + {1'b0, b} + {32'd0, cin};
      OP_SUB:  return {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
      OP_OR:   return {1'b0, a | b};
      OP_AND:  return {1'b0, a & b};
      default: return '0;
    endcase
  endfunction

  assign {alu_cout, alu_result} = alu_f(alu_a, alu_b, alu_op, alu_c_in);

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        err;
  } rsp_t;

  rsp_t exp0_q[$];
  rsp_t exp1_q[$];
  int   errors = 0;
  int   checks = 0;
  int   en_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (alu_enbl) en_cnt <= en_cnt + 1;

  // Monitor: compare every response handshake against the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      if (req0_ready || req1_ready) check("one_ready", 64'(req0_ready & req1_ready), 64'd0);
      if (rsp0_valid && rsp0_ready) begin
        if (exp0_q.size() == 0) check("rsp0_unexpected", 64'(rsp0_valid), 64'd0);
        else begin
          e = exp0_q.pop_front();
          check("rsp0_result", 64'(rsp0_result), 64'(e.res));
          check("rsp0_cout", 64'(rsp0_cout), 64'(e.cout));
          check("rsp0_err", 64'(rsp0_err), 64'(e.err));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp1_q.size() == 0) check("rsp1_unexpected", 64'(rsp1_valid), 64'd0);
        else begin
          e = exp1_q.pop_front();
          check("rsp1_result", 64'(rsp1_result), 64'(e.res));
          check("rsp1_cout", 64'(rsp1_cout), 64'(e.cout));
          check("rsp1_err", 64'(rsp1_err), 64'(e.err));
        end
      end
    end
  end

  task automatic push(input int id, input logic [31:0] r, input logic c, input logic e);
    if (id == 0) exp0_q.push_back('{res: r, cout: c, err: e});
    else         exp1_q.push_back('{res: r, cout: c, err: e});
  endtask

  // Drive one request and return #1 after the accepting edge.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    int n = 0;
    logic rdy;
    @(posedge clk); #1;
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    forever begin
      @(negedge clk);
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      n++;
      if (n > 100) begin check("accept_timeout", 64'(rdy), 64'd1); break; end
    end
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  // Count cycles from the accepting edge until the response shows up.
  task automatic wait_rsp(input int id, input int lat, input bit chk_cin, input logic exp_cin,
                          input int exp_en);
    int   k = 0;
    int   en0;
    logic v;
    en0 = en_cnt;
    do begin
      @(negedge clk);
      k++;
      if (k == 1 && chk_cin) check("alu_c_in", 64'(alu_c_in), 64'(exp_cin));
      v = (id == 0) ? rsp0_valid : rsp1_valid;
    end while (!v && k < 40);
    check("rsp_latency", 64'(k), 64'(lat));
    check("alu_enbl_cycles", 64'(en_cnt - en0), 64'(exp_en));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp0_q.size() + exp1_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp0_q.size() + exp1_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 64'({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_cout,
                     rsp1_cout, rsp0_err, rsp1_err, alu_enbl, alu_c_in, alu_op}), 64'd0);
    check({name, "_data"}, 64'(alu_a | alu_b | rsp0_result | rsp1_result), 64'd0);
  endtask

  initial begin
    int order[3];
    int n_acc;
    int t;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    @(posedge clk); #1 rst = 1'b1;

    // ADD 4 + 3 on req0.
    push(0, 32'h0000_0007, 1'b0, 1'b0);
    issue(0, 32'h4, 32'h3, OP_ADD);
    wait_rsp(0, 2, 1'b1, 1'b0, 1);
    drain();

    // SUB on req1, with and without carry-out.
    push(1, 32'h0000_0010, 1'b1, 1'b0);
    issue(1, 32'h50, 32'h40, OP_SUB);
    wait_rsp(1, 2, 1'b1, 1'b1, 1);
    push(1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    issue(1, 32'h10, 32'h20, OP_SUB);
    wait_rsp(1, 2, 1'b1, 1'b1, 1);
    drain();

    // Contention from reset: grants alternate req0, req1, req0.
    @(posedge clk); #1 rst = 1'b0;
    req0_a = 32'hFFFF_0000; req0_b = 32'h0000_FFFF; req0_op = OP_OR;  req0_valid = 1'b1;
    req1_a = 32'hFFFF_0000; req1_b = 32'h0000_FFFF; req1_op = OP_AND; req1_valid = 1'b1;
    push(0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    push(1, 32'h0000_0000, 1'b0, 1'b0);
    push(0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    check("ready_in_reset", 64'({req0_ready, req1_ready}), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    n_acc = 0;
    t = 0;
    while (n_acc < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (req0_ready || req1_ready) begin
        order[n_acc] = req1_ready ? 1 : 0;
        n_acc++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("grant_count", 64'(n_acc), 64'd3);
    check("grant_order0", 64'(order[0]), 64'd0);
    check("grant_order1", 64'(order[1]), 64'd1);
    check("grant_order2", 64'(order[2]), 64'd0);
    drain();

    // Backpressure on rsp0 blocks req1 and holds the response.
    rsp0_ready = 1'b0;
    push(0, 32'h8000_0000, 1'b0, 1'b0);
    issue(0, 32'h7FFF_FFFF, 32'h1, OP_ADD);
    push(1, 32'h0000_1234, 1'b0, 1'b0);
    req1_a = 32'h1234; req1_b = 32'h0; req1_op = OP_MOV; req1_valid = 1'b1;
    wait_rsp(0, 2, 1'b1, 1'b0, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_result", 64'(rsp0_result), 64'h8000_0000);
      check("bp_valid", 64'(rsp0_valid), 64'd1);
      check("bp_req1_ready", 64'(req1_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    t = 0;
    while (!req1_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_req1_accept", 64'(req1_ready), 64'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(1, 2, 1'b1, 1'b0, 1);
    drain();

    // Illegal opcode: immediate error response, ALU untouched.
    push(0, 32'h0, 1'b0, 1'b1);
    issue(0, 32'h5, 32'h6, 3'b110);
    wait_rsp(0, 1, 1'b0, 1'b0, 0);
    drain();

    // Reset during EXEC discards the operation.
    issue(0, 32'h1, 32'h2, OP_ADD);
    @(negedge clk);
    check("exec_busy", 64'(busy), 64'd1);
    #1 rst = 1'b0;
    #1 check_outputs_zero("reset_mid_op");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_stale_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    end
    push(0, 32'hA5A5_A5A5, 1'b0, 1'b0);
    issue(0, 32'hA5A5_A5A5, 32'h0, OP_MOV);
    wait_rsp(0, 2, 1'b1, 1'b0, 1);
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered 32-bit ALU datapath (MOV/NOT/ADD/SUB/OR/AND, carry-in, carry-out, enable) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, drives the ALU operands, opcode, carry-in and enable, waits the ALU latency, then returns result, carry-out and error to the winner.
- Sits between client engines and the ALU top.

Parameters:
- WIDTH, 32, operand/result width.
- ALU_LAT, 1, clock cycles from operands/enable applied to valid ALU result (ALU output register); legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req0_valid, req1_valid  input  1  request present.
- req0_ready, req1_ready  output  1  request accepted this cycle.
- req0_a, req1_a  input  WIDTH  operand A.
- req0_b, req1_b  input  WIDTH  operand B.
- req0_op, req1_op  input  3  ALUOp code.
- rsp0_valid, rsp1_valid  output  1  response present.
- rsp0_ready, rsp1_ready  input  1  response consumed.
- rsp0_result, rsp1_result  output  WIDTH  ALU result.
- rsp0_cout, rsp1_cout  output  1  ALU carry-out (meaningful for ADD/SUB only).
- rsp0_err, rsp1_err  output  1  illegal opcode flag.
- alu_a, alu_b  output  WIDTH  operands to ALU.
- alu_op  output  3  ALUOp to ALU.
- alu_c_in  output  1  carry-in to ALU.
- alu_enbl  output  1  ALU enable.
- alu_result  input  WIDTH  ALU result.
- alu_cout  input  1  ALU carry-out.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0, state IDLE, wait counter 0.
  - Round-robin pointer favours req0.
  - Any in-flight operation is discarded; no response is produced for it.
- Opcodes: 000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND. 110 and 111 are illegal.
- alu_c_in is 1 for SUB (two's-complement subtract), 0 for all other opcodes.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and is asserted only for the arbitration winner while in IDLE.
  - Only one ready is high in any cycle.
  - When valid and ready are both high, the block latches a, b, op and the grant id.
  - Legal op: go to EXEC and load the counter with ALU_LAT.
  - Illegal op: go directly to RESP with result=0, cout=0, err=1. The ALU is not enabled.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the one not granted last wins.
  - The pointer updates only on an accepted request.
- EXEC:
  - alu_a, alu_b, alu_op and alu_c_in are registered and held stable.
  - alu_enbl=1 for exactly ALU_LAT cycles; the counter decrements each cycle.
  - On the cycle the counter reaches 1, capture alu_result and alu_cout into the response registers, deassert alu_enbl, and go to RESP.
- RESP:
  - rspN_valid=1 for the granted id only. result/cout/err are held stable until rspN_ready=1.
  - On handshake, go to IDLE the next cycle; valid drops the same edge.
- Latency:
  - Accept edge to rsp_valid: ALU_LAT+1 cycles for a legal op, 1 cycle for an illegal op.
  - Minimum issue interval with immediate rsp_ready: ALU_LAT+2 cycles.
- alu_a, alu_b and alu_op retain their last values when idle; only alu_enbl gates the ALU.
- Request inputs are ignored outside IDLE; req_ready stays 0 there.
- Simultaneous rsp handshake and new req_valid: the new request is accepted no earlier than the next cycle (in IDLE).
- A response stalled indefinitely blocks both requesters (no bypass). busy remains 1.
- Width: the carry-out is passed through from the ALU unchanged; the block does no arithmetic itself.

Decomposition:
- Shared package alu_pkg:
  - ALUOp localparams OP_MOV..OP_AND.
  - Function op_is_legal.
  - State encoding constants ST_IDLE/ST_EXEC/ST_RESP.
- One sub-module, rr_arb2:
  - Inputs: req[1:0], accept.
  - Outputs: one-hot gnt[1:0].
  - Holds the round-robin pointer internally, with the same clk/rst.
- Everything else stays in alu_arbiter.

Test Plan:
- Single request, ALU_LAT=1: req0 ADD a=0x4, b=0x3 → rsp0_valid 2 cycles after accept, result=0x00000007, cout=0, err=0; alu_c_in=0, alu_enbl high exactly 1 cycle.
- Subtract: req1 SUB a=0x50, b=0x40 → alu_c_in=1, rsp1_result=0x00000010, cout=1. Then SUB a=0x10, b=0x20 → result=0xFFFFFFF0, cout=0.
- Contention: req0 OR 0xFFFF0000/0x0000FFFF and req1 AND same operands, both valid from reset → grant order req0 (0xFFFFFFFF), req1 (0x00000000), req0 again; only one ready per cycle.
- Backpressure: ADD 0x7FFFFFFF+0x1, hold rsp0_ready=0 for 5 cycles → rsp0_result=0x80000000 stable, req1_ready stays 0, busy=1 throughout.
- Illegal op: req0 op=3'b110 → alu_enbl never asserted, rsp0_valid 1 cycle after accept with err=1, result=0.
- Reset mid-operation: assert rst=0 during EXEC → all outputs 0 immediately. After release, no stale response appears, and a fresh MOV a=0xA5A5A5A5 returns 0xA5A5A5A5.
